// File: rtl/utx_serial.sv
// utx_serial - UART transmitter, 8 data bits, LSB first, 1 or 2 stop bits.
//
// Bytes are accepted on a valid/ready handshake and sent out as
// start(0), d0..d7, [parity], stop(1) x STOP_BITS.
// Each bit lasts BAUD_DIV cycles of clk_sys. The line idles high.
//
// The TX pin is the Q of a flop that is loaded from the registered state.
// Because of this, the line lags the state register by one cycle, and the
// start bit appears on the edge after the accept edge.
//
// Optional feature macro: UTX_PARITY_EN.
// When it is defined, an even-parity bit (XOR of the latched byte) is
// inserted between d7 and the stop bits.
//
// Parameters:
//   BAUD_DIV   clk_sys cycles per bit, 2..65535
//   STOP_BITS  number of stop bits, 1 or 2
// Ports:
//   clk_sys  in   system clock
//   rst      in   asynchronous reset, active-high
//   tx_data  in   [7:0] byte to send, sampled at accept
//   tx_vld   in   tx_data is valid
//   tx_rdy   out  block can accept a byte (FSM in IDLE)
//   tx_busy  out  a frame is in progress
//   utx_p0   out  serial TX line, idle high
module utx_serial #(
  parameter int BAUD_DIV  = 434,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_vld,
  output logic       tx_rdy,
  output logic       tx_busy,
  output logic       utx_p0
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UTX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        utx_q, utx_d;
  logic        rdy_q, busy_q;
  logic        baud_wrap_s;
  logic [15:0] baud_nxt_s;

`ifdef UTX_PARITY_EN
  logic        par_q, par_d;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  assign baud_wrap_s = (baud_q == BAUD_LAST);
  assign baud_nxt_s  = baud_wrap_s ? 16'd0 : (baud_q + 16'd1);

  // Next-state, counter and shift-register logic.
  // A wrap of the baud counter marks a bit boundary. The wrap also returns
  // the counter to 0, so every state is entered with baud_q == 0.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UTX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = 16'd0;
        bit_d  = 3'd0;
        if (tx_vld) begin
          state_d = START;
          shift_d = tx_data;
`ifdef UTX_PARITY_EN
          par_d   = even_parity(tx_data);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        baud_d = baud_nxt_s;
        if (baud_wrap_s) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        baud_d = baud_nxt_s;
        if (baud_wrap_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UTX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            bit_d = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef UTX_PARITY_EN
      PARITY: begin
        baud_d = baud_nxt_s;
        if (baud_wrap_s) begin
          state_d = STOP;
          bit_d   = 3'd0;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        // bit_q counts the stop bits sent so far.
        baud_d = baud_nxt_s;
        if (baud_wrap_s) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = 16'd0;
        bit_d   = 3'd0;
      end
    endcase
  end

  // Line level is decoded from the registered state, then registered itself.
  always_comb begin
    utx_d = 1'b1;
    case (state_q)
      START:   utx_d = 1'b0;
      DATA:    utx_d = shift_q[0];
`ifdef UTX_PARITY_EN
      PARITY:  utx_d = par_q;
`endif
      STOP:    utx_d = 1'b1;
      IDLE:    utx_d = 1'b1;
      default: utx_d = 1'b1;
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      utx_q   <= 1'b1;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      utx_q   <= utx_d;
      rdy_q   <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
    end
  end

`ifdef UTX_PARITY_EN
  // Parity of the accepted byte, held for the whole frame.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign tx_rdy  = rdy_q;
  assign tx_busy = busy_q;
  assign utx_p0  = utx_q;

endmodule

// File: tb/tb_utx_serial.sv
// Testbench for utx_serial.
// Uses two instances:
//   dut0: BAUD_DIV=4, STOP_BITS=1
//   dut1: BAUD_DIV=3, STOP_BITS=2
// Drivers push the expected byte (with its hand-computed parity bit) into a
// per-instance queue. A line monitor pops an entry at every start bit and
// checks the frame cycle by cycle.
`timescale 1ns/1ps
module tb_utx_serial;
  localparam int B0 = 4;
  localparam int S0 = 1;
  localparam int B1 = 3;
  localparam int S1 = 2;
`ifdef UTX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Frame lengths: 40 and 33 cycles, or 44 and 36 cycles with parity.
  localparam int LEN0 = (10 + PB + S0 - 1) * B0;
  localparam int LEN1 = (10 + PB + S1 - 1) * B1;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic [7:0] d1 = 8'h00;
  logic       v0 = 1'b0;
  logic       v1 = 1'b0;
  logic       r0, r1, b0, b1, l0, l1;
  logic [1:0] line_s, busy_s;

  exp_t q0[$];
  exp_t q1[$];
  int   starts0[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cnt[2] = '{0, 0};
  int   acc_cyc[2] = '{0, 0};
  int   bcnt[2]    = '{0, 0};
  logic bprev[2]   = '{1'b0, 1'b0};

  assign line_s = {l1, l0};
  assign busy_s = {b1, b0};

  always #5 clk = ~clk;

  utx_serial #(.BAUD_DIV(B0), .STOP_BITS(S0)) u_dut0 (
    .clk_sys(clk), .rst(rst), .tx_data(d0), .tx_vld(v0),
    .tx_rdy(r0), .tx_busy(b0), .utx_p0(l0)
  );

  utx_serial #(.BAUD_DIV(B1), .STOP_BITS(S1)) u_dut1 (
    .clk_sys(clk), .rst(rst), .tx_data(d1), .tx_vld(v1),
    .tx_rdy(r1), .tx_busy(b1), .utx_p0(l1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle counter: after posedge N, cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  // Accept recorder: counts each handshake and records its edge number.
  always @(posedge clk) begin
    if (!rst && v0 && r0) begin
      acc_cnt[0]++;
      acc_cyc[0] = cyc + 1;
    end
    if (!rst && v1 && r1) begin
      acc_cnt[1]++;
      acc_cyc[1] = cyc + 1;
    end
  end

  // Busy-length checker: each busy period must equal one frame.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        bcnt[i]  = 0;
        bprev[i] = 1'b0;
      end else begin
        if (busy_s[i]) begin
          bcnt[i]++;
        end else if (bprev[i]) begin
          chk($sformatf("busy_len%0d", i), bcnt[i], (i == 0) ? LEN0 : LEN1);
          bcnt[i] = 0;
        end
        bprev[i] = busy_s[i];
      end
    end
  end

  // Line monitor for one instance.
  task automatic mon(input int id);
    logic prev, ev, act, ab;
    exp_t e;
    int   bt, nb, st;
    bt   = (id == 0) ? B0 : B1;
    nb   = 10 + PB + ((id == 0) ? S0 : S1) - 1;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !line_s[id]) begin
        st = cyc;
        chk($sformatf("start_latency%0d", id), st, acc_cyc[id] + 1);
        if (id == 0) starts0.push_back(st);
        ab = 1'b0;
        e  = '0;
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame%0d: start bit at cycle %0d, expected none", id, st);
          ab = 1'b1;
        end else begin
          e = (id == 0) ? q0.pop_front() : q1.pop_front();
        end
        for (int k = 0; k < nb && !ab; k++) begin
          if (k == 0)
            ev = 1'b0;
          else if (k <= 8)
            ev = e.data[k-1];
          else if (PB == 1 && k == 9)
            ev = e.par;
          else
            ev = 1'b1;
          act = ev;
          for (int c = 0; c < bt; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            if (rst) begin
              ab = 1'b1;
              break;
            end
            if (line_s[id] !== ev) act = line_s[id];
          end
          if (!ab) chk($sformatf("dut%0d_byte%02h_bit%0d", id, e.data, k), act, ev);
        end
      end
      prev = line_s[id];
    end
  endtask

  initial mon(0);
  initial mon(1);

  // Drives one byte on the selected instance and waits for the accept.
  task automatic send(input int id, input logic [7:0] d, input logic p);
    int n;
    n = acc_cnt[id];
    @(negedge clk);
    if (id == 0) begin
      d0 = d;
      v0 = 1'b1;
      q0.push_back({d, p});
    end else begin
      d1 = d;
      v1 = 1'b1;
      q1.push_back({d, p});
    end
    for (int i = 0; i < 200 && acc_cnt[id] == n; i++) @(negedge clk);
    chk($sformatf("accept%0d_%02h", id, d), acc_cnt[id], n + 1);
    if (id == 0) v0 = 1'b0;
    else v1 = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300 && (b0 || b1 || q0.size() != 0 || q1.size() != 0); i++)
      @(negedge clk);
    chk("idle_timeout", (i < 300) ? 1 : 0, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1 chk("rst_async_line0", l0, 1);
    chk("rst_async_line1", l1, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_rdy", r0, 1);
    chk("rst_busy", b0, 0);
  endtask

  initial begin
    int n, lows;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_line", l0, 1);
    chk("reset_rdy", r0, 1);
    chk("reset_busy", b0, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while idle.
    pulse_rst();
    repeat (3) @(negedge clk);

    // Single byte 0x55; the parity bit of 0x55 is 0.
    send(0, 8'h55, 1'b0);
    chk("rdy_low_after_accept", r0, 0);
    wait_idle();

    // Reset in the middle of the data bits of 0x00.
    send(0, 8'h00, 1'b0);
    repeat (10) @(negedge clk);
    chk("line_low_mid_data", l0, 0);
    pulse_rst();
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!l0) lows++;
    end
    chk("no_low_after_reset", lows, 0);
    q0.delete();

    // Back-to-back 0xA5 then 0x3C with tx_vld held high.
    n = acc_cnt[0];
    @(negedge clk);
    d0 = 8'hA5;
    v0 = 1'b1;
    q0.push_back({8'hA5, 1'b0});
    q0.push_back({8'h3C, 1'b0});
    for (int i = 0; i < 200 && acc_cnt[0] == n; i++) @(negedge clk);
    d0 = 8'h3C;
    for (int i = 0; i < 200 && acc_cnt[0] == n + 1; i++) @(negedge clk);
    v0 = 1'b0;
    wait_idle();
    chk("b2b_accepts", acc_cnt[0], n + 2);
    if (starts0.size() >= 2)
      chk("b2b_spacing", starts0[starts0.size()-1] - starts0[starts0.size()-2],
          (10 + PB) * B0 + 1);
    else
      chk("b2b_frames", starts0.size(), 2);

    // tx_vld pulse while busy is ignored; the line keeps carrying 0xFF.
    n = acc_cnt[0];
    send(0, 8'hFF, 1'b0);
    repeat (9) @(negedge clk);
    d0 = 8'h00;
    v0 = 1'b1;
    chk("rdy_while_busy", r0, 0);
    @(negedge clk);
    v0 = 1'b0;
    wait_idle();
    chk("busy_ignore_accepts", acc_cnt[0], n + 1);

    // Two stop bits, BAUD_DIV=3: 0x80 has parity 1.
    send(1, 8'h80, 1'b1);
    wait_idle();

    // Parity vectors: 0x07 -> 1, 0x03 -> 0.
    send(0, 8'h07, 1'b1);
    wait_idle();
    send(0, 8'h03, 1'b0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
